// File: rtl/histogram_bin_accum_if.sv
// Pixel-stream, readout and status bundle for histogram_bin_accum.
// master = pixel source / readout consumer, slave = the histogram block.
interface histogram_bin_accum_if #(
  parameter int PIX_W = 8,
  parameter int NBINS = 256,
  parameter int CNT_W = 16,
  parameter int TOT_W = 32
);
  localparam int BIN_W = $clog2(NBINS);

  logic             clear;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_ready;
  logic [BIN_W-1:0] rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic [BIN_W-1:0] peak_bin;
  logic [CNT_W-1:0] peak_cnt;
  logic [TOT_W-1:0] total_cnt;
  logic             sat_flag;
  logic             busy;

  modport master (
    output clear, pix_valid, pix_data, rd_sel,
    input  pix_ready, rd_data, peak_bin, peak_cnt, total_cnt, sat_flag, busy
  );

  modport slave (
    input  clear, pix_valid, pix_data, rd_sel,
    output pix_ready, rd_data, peak_bin, peak_cnt, total_cnt, sat_flag, busy
  );
endinterface

// File: rtl/histogram_bin_accum.sv
// Intensity histogram: NBINS saturating bin counters fed by a pixel stream,
// registered bin readout, peak-bin tracking, total pixel count and a
// one-bin-per-cycle clear sweep.
module histogram_bin_accum #(
  parameter int PIX_W = 8,
  parameter int NBINS = 256,
  parameter int CNT_W = 16,
  parameter int TOT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  histogram_bin_accum_if.slave   hist
);
  localparam int                 BIN_W    = $clog2(NBINS);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [TOT_W-1:0]   TOT_MAX  = '1;
  localparam logic [BIN_W-1:0]   LAST_BIN = BIN_W'(NBINS - 1);

  typedef enum logic {ST_ACCUM, ST_CLEAR} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_bins [NBINS];
  logic [BIN_W-1:0] r_clr_ptr;
  logic [CNT_W-1:0] r_rd_data;
  logic [BIN_W-1:0] r_peak_bin;
  logic [CNT_W-1:0] r_peak_cnt;
  logic [TOT_W-1:0] r_total;
  logic             r_sat;

  logic             w_ready;
  logic             w_busy;
  logic             w_start_clear;
  logic             w_accept;
  logic [BIN_W-1:0] w_idx;
  logic [CNT_W-1:0] w_cur;
  logic [CNT_W-1:0] w_inc;
  logic             w_bin_full;
  logic             w_tot_full;

  // Bin index is the top BIN_W bits of the intensity.
  assign w_idx      = hist.pix_data[PIX_W-1 -: BIN_W];
  assign w_cur      = r_bins[w_idx];
  assign w_bin_full = (w_cur == CNT_MAX);
  assign w_tot_full = (r_total == TOT_MAX);
  assign w_inc      = w_bin_full ? w_cur : w_cur + CNT_W'(1);
  assign w_accept   = hist.pix_valid && w_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_ACCUM;
    else       r_state <= w_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    w_next        = r_state;
    w_ready       = 1'b0;
    w_busy        = 1'b0;
    w_start_clear = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        w_ready = 1'b1;
        if (hist.clear) begin
          w_next        = ST_CLEAR;
          w_start_clear = 1'b1;
        end
      end
      ST_CLEAR: begin
        w_busy = 1'b1;
        if (r_clr_ptr == LAST_BIN) w_next = ST_ACCUM;
      end
      default: w_next = ST_ACCUM;
    endcase
  end

  // Bin storage: sweep zeroes one bin per cycle, otherwise accepted pixels increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the bins must read zero straight out of reset, so the array is
      // built from resettable flops rather than a RAM macro.
      for (int i = 0; i < NBINS; i++) r_bins[i] <= '0;
    end else if (w_busy) begin
      r_bins[r_clr_ptr] <= '0;
    end else if (w_accept) begin
      // NOTE: non-blocking update, so the readout below samples the
      // pre-increment count on this same edge.
      r_bins[w_idx] <= w_inc;
    end
  end

  // Sweep pointer: wraps back to 0 after the last bin, ready for the next sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_clr_ptr <= '0;
    else if (w_busy) r_clr_ptr <= r_clr_ptr + BIN_W'(1);
  end

  // Registered readout of any bin, active in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_data <= '0;
    else       r_rd_data <= r_bins[hist.rd_sel];
  end

  // Total count, sticky saturation flag and peak tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total    <= '0;
      r_sat      <= 1'b0;
      r_peak_bin <= '0;
      r_peak_cnt <= '0;
    end else if (w_start_clear) begin
      // A pixel accepted in the clear cycle is discarded with everything else.
      r_total    <= '0;
      r_sat      <= 1'b0;
      r_peak_bin <= '0;
      r_peak_cnt <= '0;
    end else if (w_accept) begin
      r_total <= w_tot_full ? r_total : r_total + TOT_W'(1);
      r_sat   <= r_sat | w_bin_full | w_tot_full;
      if (w_idx == r_peak_bin) begin
        r_peak_cnt <= w_inc;
      end else if (w_inc > r_peak_cnt) begin
        // Strictly greater: on a tie the earlier winner keeps the peak.
        r_peak_cnt <= w_inc;
        r_peak_bin <= w_idx;
      end
    end
  end

  assign hist.pix_ready = w_ready;
  assign hist.busy      = w_busy;
  assign hist.rd_data   = r_rd_data;
  assign hist.peak_bin  = r_peak_bin;
  assign hist.peak_cnt  = r_peak_cnt;
  assign hist.total_cnt = r_total;
  assign hist.sat_flag  = r_sat;
endmodule
